// File: rtl/timestamp_framer_pkg.sv
// Shared codes for the timestamp framer: host command bytes, frame header bytes
// and the TX framing state encoding.
package timestamp_framer_pkg;

  localparam logic [7:0] CMD_ACK1 = 8'h00;
  localparam logic [7:0] CMD_ACK2 = 8'h01;
  localparam logic [7:0] CMD_SWL1 = 8'h02;
  localparam logic [7:0] CMD_SWL2 = 8'h03;

  localparam logic [7:0] HDR_CH1 = 8'h00;
  localparam logic [7:0] HDR_CH2 = 8'h01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/timestamp_framer.sv
// Frames latched 64-bit counter values from two channels into header+data byte
// streams, and decodes single-byte host commands into latch/reset pulses.
module timestamp_framer
  import timestamp_framer_pkg::*;
#(
  parameter int unsigned pBYTES = 5,
  parameter int unsigned pBADW  = 8
) (
  input  logic             iCLK,
  input  logic             rstA,
  input  logic             iRdy1,
  input  logic [31:0]      iCnt1Lo,
  input  logic [31:0]      iCnt1Hi,
  input  logic             iRdy2,
  input  logic [31:0]      iCnt2Lo,
  input  logic [31:0]      iCnt2Hi,
  input  logic             iRxValid,
  input  logic [7:0]       iRxData,
  input  logic             iTxReady,
  output logic             oTxValid,
  output logic [7:0]       oTxData,
  output logic             oResetLatch1,
  output logic             oResetLatch2,
  output logic             oLatch1,
  output logic             oLatch2,
  output logic             oBusy,
  output logic [pBADW-1:0] oBadCmd
);

  localparam int unsigned SHW  = 8 * pBYTES;
  localparam int unsigned CNTW = (pBYTES > 1) ? $clog2(pBYTES) : 1;

  logic [1:0]       r_state, w_state_nxt;
  logic [SHW-1:0]   r_shift, w_shift_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_chan, w_chan_nxt;   // in-flight channel: 0 = ch1, 1 = ch2
  logic             r_last, w_last_nxt;   // most recently selected channel
  logic             r_txv, w_txv_nxt;
  logic [7:0]       r_txd, w_txd_nxt;
  logic             r_sent1, w_sent1_nxt;
  logic             r_sent2, w_sent2_nxt;
  logic             r_busy, w_busy_nxt;

  logic             r_rst1, r_rst2, r_lat1, r_lat2;
  logic [pBADW-1:0] r_bad;

  logic [63:0]      w_cnt1, w_cnt2;
  logic             w_elig1, w_elig2, w_pick2, w_accept, w_hdr_acc;
  logic             w_inflight1, w_inflight2;

  assign w_cnt1      = {iCnt1Hi, iCnt1Lo};
  assign w_cnt2      = {iCnt2Hi, iCnt2Lo};
  assign w_elig1     = iRdy1 & ~r_sent1;
  assign w_elig2     = iRdy2 & ~r_sent2;
  // Channel 2 wins only if channel 1 is not waiting or channel 1 went last
  assign w_pick2     = w_elig2 & (~w_elig1 | ~r_last);
  assign w_accept    = r_txv & iTxReady;
  assign w_hdr_acc   = (r_state == ST_HDR) & w_accept;
  assign w_inflight1 = (r_state != ST_IDLE) & ~r_chan;
  assign w_inflight2 = (r_state != ST_IDLE) & r_chan;

  if (SHW < 64) begin : g_unused
    logic w_unused;
    assign w_unused = ^{w_cnt1[63:SHW], w_cnt2[63:SHW]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_chan_nxt  = r_chan;
    w_last_nxt  = r_last;
    w_txv_nxt   = r_txv;
    w_txd_nxt   = r_txd;
    w_sent1_nxt = r_sent1;
    w_sent2_nxt = r_sent2;

    case (r_state)
      ST_IDLE: begin
        if (w_elig1 | w_elig2) begin
          w_state_nxt = ST_HDR;
          w_txv_nxt   = 1'b1;
          w_chan_nxt  = w_pick2;
          w_last_nxt  = w_pick2;
          w_txd_nxt   = w_pick2 ? HDR_CH2 : HDR_CH1;
          w_shift_nxt = w_pick2 ? w_cnt2[SHW-1:0] : w_cnt1[SHW-1:0];
        end
      end
      ST_HDR: begin
        if (w_accept) begin
          w_state_nxt = ST_DATA;
          w_txd_nxt   = r_shift[SHW-1 -: 8];
          w_shift_nxt = r_shift << 8;
          w_cnt_nxt   = CNTW'(pBYTES - 1);
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
            w_txv_nxt   = 1'b0;
            w_txd_nxt   = 8'h00;
          end else begin
            w_txd_nxt   = r_shift[SHW-1 -: 8];
            w_shift_nxt = r_shift << 8;
            w_cnt_nxt   = r_cnt - CNTW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_txv_nxt   = 1'b0;
        w_txd_nxt   = 8'h00;
      end
    endcase

    // A latched value counts as sent once its header is taken; it re-arms only
    // after the latch drops and no frame for that channel is outstanding.
    if (w_hdr_acc & ~r_chan)
      w_sent1_nxt = 1'b1;
    else if (~iRdy1 & ~w_inflight1)
      w_sent1_nxt = 1'b0;

    if (w_hdr_acc & r_chan)
      w_sent2_nxt = 1'b1;
    else if (~iRdy2 & ~w_inflight2)
      w_sent2_nxt = 1'b0;

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge iCLK or posedge rstA) begin
    if (rstA) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_chan  <= 1'b0;
      r_last  <= 1'b1;
      r_txv   <= 1'b0;
      r_txd   <= 8'h00;
      r_sent1 <= 1'b0;
      r_sent2 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chan  <= w_chan_nxt;
      r_last  <= w_last_nxt;
      r_txv   <= w_txv_nxt;
      r_txd   <= w_txd_nxt;
      r_sent1 <= w_sent1_nxt;
      r_sent2 <= w_sent2_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Host command decode, independent of the TX framing state
  always_ff @(posedge iCLK or posedge rstA) begin
    if (rstA) begin
      r_rst1 <= 1'b0;
      r_rst2 <= 1'b0;
      r_lat1 <= 1'b0;
      r_lat2 <= 1'b0;
      r_bad  <= '0;
    end else begin
      r_rst1 <= 1'b0;
      r_rst2 <= 1'b0;
      r_lat1 <= 1'b0;
      r_lat2 <= 1'b0;
      if (iRxValid) begin
        case (iRxData)
          CMD_ACK1: r_rst1 <= r_sent1;
          CMD_ACK2: r_rst2 <= r_sent2;
          CMD_SWL1: r_lat1 <= 1'b1;
          CMD_SWL2: r_lat2 <= 1'b1;
          default: begin
            if (r_bad != '1)
              r_bad <= r_bad + pBADW'(1);
          end
        endcase
      end
    end
  end

  assign oTxValid     = r_txv;
  assign oTxData      = r_txd;
  assign oBusy        = r_busy;
  assign oResetLatch1 = r_rst1;
  assign oResetLatch2 = r_rst2;
  assign oLatch1      = r_lat1;
  assign oLatch2      = r_lat2;
  assign oBadCmd      = r_bad;

endmodule

// File: tb/tb_timestamp_framer.sv
// Bench for timestamp_framer: command table, directed framing sequences and a
// randomized run checked against a per-channel frame model.
module tb_timestamp_framer;

  localparam int unsigned P  = 5;
  localparam int unsigned BW = 8;
  localparam int unsigned VW = 8 * P;

  logic          iCLK = 1'b0;
  logic          rstA = 1'b1;
  logic          iRdy1 = 1'b0, iRdy2 = 1'b0;
  logic [31:0]   iCnt1Lo = '0, iCnt1Hi = '0, iCnt2Lo = '0, iCnt2Hi = '0;
  logic          iRxValid = 1'b0;
  logic [7:0]    iRxData = '0;
  logic          iTxReady = 1'b0;
  logic          oTxValid, oResetLatch1, oResetLatch2, oLatch1, oLatch2, oBusy;
  logic [7:0]    oTxData;
  logic [BW-1:0] oBadCmd;

  always #5 iCLK = ~iCLK;

  timestamp_framer #(.pBYTES(P), .pBADW(BW)) dut (
    .iCLK(iCLK), .rstA(rstA),
    .iRdy1(iRdy1), .iCnt1Lo(iCnt1Lo), .iCnt1Hi(iCnt1Hi),
    .iRdy2(iRdy2), .iCnt2Lo(iCnt2Lo), .iCnt2Hi(iCnt2Hi),
    .iRxValid(iRxValid), .iRxData(iRxData), .iTxReady(iTxReady),
    .oTxValid(oTxValid), .oTxData(oTxData),
    .oResetLatch1(oResetLatch1), .oResetLatch2(oResetLatch2),
    .oLatch1(oLatch1), .oLatch2(oLatch2), .oBusy(oBusy), .oBadCmd(oBadCmd)
  );

  typedef struct {
    logic [7:0]    cmd;
    logic [3:0]    pulses;   // {rst1, rst2, lat1, lat2}
    logic [BW-1:0] bad;
  } rx_vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    q_tx[$];
  logic          hold_v = 1'b0;
  logic [7:0]    hold_d = '0;
  logic [VW-1:0] exp1[$], exp2[$];
  int            st1 = 0, st2 = 0;   // 0 idle, 1 frame expected, 2 frame seen

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observe the TX handshake mid-cycle, then advance to just after the next edge
  task automatic tick();
    @(negedge iCLK);
    if (rstA) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(oTxValid), 64'd1);
        check("hold_data", 64'(oTxData), 64'(hold_d));
      end
      hold_v = oTxValid && !iTxReady;
      hold_d = oTxData;
      if (oTxValid && iTxReady) q_tx.push_back(oTxData);
    end
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [7:0] frame_byte(input logic [63:0] v, input int k);
    return 8'(v >> (8 * (int'(P) - 1 - k)));
  endfunction

  task automatic expect_frame(input string name, input logic [7:0] hdr, input logic [63:0] v,
                              input int bound);
    int n = 0;
    while (q_tx.size() < P + 1 && n < bound) begin
      tick();
      n++;
    end
    if (q_tx.size() < P + 1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bytes, expected %0d", name, q_tx.size(), P + 1);
      q_tx.delete();
    end else begin
      check({name, "_hdr"}, 64'(q_tx.pop_front()), 64'(hdr));
      for (int k = 0; k < int'(P); k++)
        check({name, "_data"}, 64'(q_tx.pop_front()), 64'(frame_byte(v, k)));
    end
  endtask

  task automatic rx(input logic [7:0] b);
    iRxValid = 1'b1;
    iRxData  = b;
    tick();
    iRxValid = 1'b0;
  endtask

  task automatic check_pulses(input string name, input logic [3:0] exp);
    check(name, 64'({oResetLatch1, oResetLatch2, oLatch1, oLatch2}), 64'(exp));
  endtask

  task automatic idle_both();
    iRdy1 = 1'b0;
    iRdy2 = 1'b0;
    repeat (3) tick();
  endtask

  // Split the observed stream into frames and match each against its channel's queue
  task automatic parse_frames();
    logic [7:0]    hdr;
    logic [VW-1:0] val;
    while (q_tx.size() >= P + 1) begin
      hdr = q_tx.pop_front();
      val = '0;
      for (int k = 0; k < int'(P); k++) val = (val << 8) | VW'(q_tx.pop_front());
      if (hdr == 8'h00) begin
        if (exp1.size() == 0) check("rand_ch1_unexpected", 64'(val), 64'd0 - 64'd1);
        else begin
          check("rand_ch1", 64'(val), 64'(exp1.pop_front()));
          st1 = 2;
        end
      end else if (hdr == 8'h01) begin
        if (exp2.size() == 0) check("rand_ch2_unexpected", 64'(val), 64'd0 - 64'd1);
        else begin
          check("rand_ch2", 64'(val), 64'(exp2.pop_front()));
          st2 = 2;
        end
      end else begin
        check("rand_hdr", 64'(hdr), 64'd0);
      end
    end
  endtask

  rx_vec_t tbl[7];

  initial begin
    logic [63:0] v1, v2, v3;
    int          n;

    tbl[0] = '{8'h00, 4'b0000, 8'd0};   // ack1 with nothing sent: ignored
    tbl[1] = '{8'h01, 4'b0000, 8'd0};
    tbl[2] = '{8'h02, 4'b0010, 8'd0};
    tbl[3] = '{8'h03, 4'b0001, 8'd0};
    tbl[4] = '{8'h7F, 4'b0000, 8'd1};
    tbl[5] = '{8'hFF, 4'b0000, 8'd2};
    tbl[6] = '{8'h04, 4'b0000, 8'd3};

    repeat (2) @(posedge iCLK);
    #1;
    check("reset_outputs",
          64'({oTxValid, oTxData, oResetLatch1, oResetLatch2, oLatch1, oLatch2, oBusy, oBadCmd}),
          64'd0);
    rstA = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      rx(tbl[i].cmd);
      check_pulses("cmd_pulse", tbl[i].pulses);
      check("cmd_bad", 64'(oBadCmd), 64'(tbl[i].bad));
      tick();
      check_pulses("cmd_pulse_end", 4'b0000);
    end

    for (int i = 0; i < 252; i++) begin
      rx(8'h80);
      tick();
    end
    check("bad_reach_max", 64'(oBadCmd), 64'hFF);
    for (int i = 0; i < 4; i++) begin
      rx(8'h55);
      tick();
    end
    check("bad_saturate", 64'(oBadCmd), 64'hFF);

    // Single frame with the transmitter always ready, byte-by-byte timing
    iTxReady = 1'b1;
    iCnt1Lo  = 32'h89ABCDEF;
    iCnt1Hi  = 32'h01234567;
    iRdy1    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("single_valid", 64'(oTxValid), 64'd1);
      check("single_byte", 64'(oTxData), (k == 0) ? 64'h00 : 64'(frame_byte({iCnt1Hi, iCnt1Lo}, k - 1)));
      check("single_busy", 64'(oBusy), 64'd1);
    end
    tick();
    check("single_end", 64'({oTxValid, oBusy}), 64'd0);
    q_tx.delete();

    // Ack flow: acks pulse while sent, repeat acks pulse again, none once re-armed
    rx(8'h00);
    check_pulses("ack1_pulse", 4'b1000);
    tick();
    check_pulses("ack1_end", 4'b0000);
    rx(8'h00);
    check_pulses("ack1_repeat", 4'b1000);
    rx(8'h01);
    check_pulses("ack2_unsent", 4'b0000);
    iRdy1 = 1'b0;
    repeat (2) tick();
    rx(8'h00);
    check_pulses("ack1_cleared", 4'b0000);
    v1 = 64'hFEDCBA9876543210;
    {iCnt1Hi, iCnt1Lo} = v1;
    iRdy1 = 1'b1;
    expect_frame("reframe", 8'h00, v1, 20);
    repeat (10) tick();
    check("reframe_once", 64'(q_tx.size()), 64'd0);

    // Backpressure on channel 2, ack mid-frame, input change after capture
    v2 = 64'h00000055DEADBEEF;
    {iCnt2Hi, iCnt2Lo} = v2;
    iRdy2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      iTxReady = (i % 2 == 1);
      if (i == 2) {iCnt2Hi, iCnt2Lo} = 64'h1234567890ABCDEF;
      if (i == 8) begin
        iRxValid = 1'b1;
        iRxData  = 8'h01;
      end
      tick();
      if (i == 8) begin
        iRxValid = 1'b0;
        check_pulses("ack2_inflight", 4'b0100);
        check("busy_inflight", 64'(oBusy), 64'd1);
      end
    end
    iTxReady = 1'b1;
    expect_frame("backpressure", 8'h01, v2, 20);

    // Simultaneous requests after reset priority, then round-robin
    idle_both();
    v1 = 64'h00000011A1A2A3A4;
    v2 = 64'h00000022B1B2B3B4;
    {iCnt1Hi, iCnt1Lo} = v1;
    {iCnt2Hi, iCnt2Lo} = v2;
    iRdy1 = 1'b1;
    iRdy2 = 1'b1;
    expect_frame("both_first", 8'h00, v1, 20);
    expect_frame("both_second", 8'h01, v2, 20);
    repeat (15) tick();
    check("both_once", 64'(q_tx.size()), 64'd0);
    idle_both();
    v3 = 64'h00000033C1C2C3C4;
    {iCnt1Hi, iCnt1Lo} = v3;
    iRdy1 = 1'b1;
    expect_frame("ch1_alone", 8'h00, v3, 20);
    idle_both();
    iRdy1 = 1'b1;
    iRdy2 = 1'b1;
    expect_frame("rr_first", 8'h01, v2, 20);
    expect_frame("rr_second", 8'h00, v3, 20);
    idle_both();

    // Reset after the third byte: frame abandoned, then resent whole
    v1 = 64'h0000004455667788;
    {iCnt1Hi, iCnt1Lo} = v1;
    iRdy1 = 1'b1;
    repeat (4) tick();
    check("pre_reset_bytes", 64'(q_tx.size()), 64'd3);
    rstA = 1'b1;
    #1;
    check("reset_drop", 64'({oTxValid, oBusy, oBadCmd}), 64'd0);
    tick();
    q_tx.delete();
    rstA = 1'b0;
    expect_frame("after_reset", 8'h00, v1, 20);
    idle_both();
    q_tx.delete();

    // Randomized traffic against the per-channel frame model
    for (int c = 0; c < 3000; c++) begin
      iTxReady = 1'($urandom_range(0, 1));
      if (st1 == 0 && $urandom_range(0, 7) == 0) begin
        {iCnt1Hi, iCnt1Lo} = {$urandom, $urandom};
        iRdy1 = 1'b1;
        exp1.push_back(VW'({iCnt1Hi, iCnt1Lo}));
        st1 = 1;
      end else if (st1 == 2 && $urandom_range(0, 3) == 0) begin
        iRdy1 = 1'b0;
        st1 = 0;
      end
      if (st2 == 0 && $urandom_range(0, 7) == 0) begin
        {iCnt2Hi, iCnt2Lo} = {$urandom, $urandom};
        iRdy2 = 1'b1;
        exp2.push_back(VW'({iCnt2Hi, iCnt2Lo}));
        st2 = 1;
      end else if (st2 == 2 && $urandom_range(0, 3) == 0) begin
        iRdy2 = 1'b0;
        st2 = 0;
      end
      tick();
      parse_frames();
    end
    iTxReady = 1'b1;
    n = 0;
    while ((st1 == 1 || st2 == 1) && n < 200) begin
      tick();
      parse_frames();
      n++;
    end
    check("rand_pending1", 64'(exp1.size()), 64'd0);
    check("rand_pending2", 64'(exp2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
